branch_predict_unit: RTL

Parametrised successor to the single-cycle branch decision logic. Resolves conditional branches (beq/bne/blt/bge/bltu/bgeu) from ALU flags. Adds a direct-mapped table of 2-bit saturating counters that predicts branch direction at fetch and trains at resolve. Sits between fetch (prediction lookup) and execute (resolution, mispredict signalling to PC select).

---
 rtl/branch_predict_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution from ALU flags plus a direct-mapped table of 2-bit saturating
// direction counters. Define BPU_PERF_CNT_EN to build the branch/mispredict counters.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_f,
  output logic             predict_taken,
  input  logic             resolve_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc_e,
  input  logic             predicted_e,
  input  logic             Zero,
  input  logic             Negative,
  input  logic             Overflow,
  input  logic             carry_out,
  output logic             PCSrc,
  output logic             mispredict,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES);
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  ctr_e             bht_q [BHT_ENTRIES];
  ctr_e             bht_d [BHT_ENTRIES];
  ctr_e             cur_ctr;
  ctr_e             nxt_ctr;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             resolve_active;
  logic             legal;
  logic             taken;
  logic             train;
  logic             unused_pc_bits;

  assign rd_idx = pc_f[IDX_W+1:2];
  assign wr_idx = pc_e[IDX_W+1:2];
  assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0],
                            pc_e[XLEN-1:IDX_W+2], pc_e[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign predict_taken = (bht_q[rd_idx] == WEAK_T) || (bht_q[rd_idx] == STRONG_T);

  always_comb begin
    resolve_active = resolve_valid && (opcode == OPC_BRANCH);
    taken          = 1'b0;
    legal          = 1'b1;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Negative ^ Overflow;
      3'b101:  taken = !(Negative ^ Overflow);
      3'b110:  taken = !carry_out;
      3'b111:  taken = carry_out;
      default: legal = 1'b0;
    endcase
    train          = resolve_active && legal;
    illegal_branch = resolve_active && !legal;
    PCSrc          = train && taken;
    mispredict     = train && (taken != predicted_e);
  end

  always_comb begin
    cur_ctr = bht_q[wr_idx];
    case (cur_ctr)
      STRONG_NT: nxt_ctr = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt_ctr = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt_ctr = taken ? STRONG_T : WEAK_NT;
      default:   nxt_ctr = taken ? STRONG_T : WEAK_T;
    endcase
    bht_d = bht_q;
    if (train) begin
      bht_d[wr_idx] = nxt_ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bht_q <= '{default: WEAK_NT};
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (train && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (mispredict && (mispredict_cnt_q != '1)) begin
      mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule
